// File: rtl/pulse_ts_pkg.sv
// pulse_ts_pkg: shared types and constants for the pulse timestamper slice.
//   ts_state_e : FSM state encoding (IDLE / HIGH / DEAD)
//   evt_rec_t  : event record {timestamp, tot, saturated} at the default widths;
//                the top builds the same layout from its own width parameters
//   DROP_W     : width of the saturating drop counter
package pulse_ts_pkg;

  localparam int TS_WIDTH_DEF  = 24;
  localparam int TOT_WIDTH_DEF = 8;
  localparam int DROP_W        = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_DEAD = 2'd2
  } ts_state_e;

  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0]  timestamp;
    logic [TOT_WIDTH_DEF-1:0] tot;
    logic                     saturated;
  } evt_rec_t;

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous show-ahead FIFO. The head entry is presented on
// o_dout combinationally (zero when empty); a pop takes effect at the edge.
// A push while full is accepted only if a pop happens in the same cycle.
//   i_clk, i_rst    clock, synchronous active-high reset (clears pointers)
//   i_push, i_din   write request and data
//   i_pop           read request (ignored when empty)
//   o_dout          head entry
//   o_full, o_empty status
//   o_level         stored entries, 0..DEPTH
module event_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 33
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic         w_do_push, w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_level   = r_wr - r_rd;
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (o_level == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, the slot being popped is the one written, so the push is safe.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_timestamper.sv
// pulse_timestamper: synchronises an asynchronous comparator pulse, timestamps
// each rising edge with a free-running counter, measures time-over-threshold
// and queues one event per pulse in a show-ahead FIFO drained via valid/ready.
// Optional build macro: MIN_WIDTH_FILTER_EN -- discard pulses with ToT below
// MIN_WIDTH (not counted as drops, no deadtime after them).
//   CLK_FAST, RESET_FAST   clock, synchronous active-high reset
//   PULSE_IN               asynchronous comparator output
//   EVT_VALID/EVT_READY    readout handshake for the FIFO head
//   EVT_TIMESTAMP/TOT/SATURATED  head event fields
//   FIFO_LEVEL             stored events
//   DROP_COUNT             events lost to a full FIFO, saturating
module pulse_timestamper
  import pulse_ts_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int TOT_WIDTH  = TOT_WIDTH_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int DEADTIME   = 8,
  parameter int MIN_WIDTH  = 2
) (
  input  logic                          CLK_FAST,
  input  logic                          RESET_FAST,
  input  logic                          PULSE_IN,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [TS_WIDTH-1:0]           EVT_TIMESTAMP,
  output logic [TOT_WIDTH-1:0]          EVT_TOT,
  output logic                          EVT_SATURATED,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic [DROP_W-1:0]             DROP_COUNT
);
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [TOT_WIDTH-1:0] TOT_MAX = '1;
`ifdef MIN_WIDTH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef struct packed {
    logic [TS_WIDTH-1:0]  timestamp;
    logic [TOT_WIDTH-1:0] tot;
    logic                 saturated;
  } evt_t;

  logic                 r_sync1, r_sync2, r_prev;
  logic [1:0]           r_hold;
  logic [TS_WIDTH-1:0]  r_cnt, r_ts;
  logic [TOT_WIDTH-1:0] r_tot;
  logic                 r_sat;
  logic [DW-1:0]        r_dead;
  logic [DROP_W-1:0]    r_drop;
  ts_state_e            r_state, w_state_nxt;

  logic w_rise, w_commit, w_keep, w_push, w_pop, w_full, w_empty;
  evt_t w_evt_in, w_evt_out;

  // Synchroniser, edge detect and timestamp counter. The sync flops clear to
  // 0 on reset, so prev is held high until they have refilled from the pin;
  // otherwise a level already high at release would look like a fresh rise.
  always_ff @(posedge CLK_FAST) begin
    if (RESET_FAST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b1;
      r_hold  <= 2'b11;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= PULSE_IN;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2 | r_hold[0];
      r_hold  <= {1'b0, r_hold[1]};
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_keep = !FILTER_EN || (int'(r_tot) >= MIN_WIDTH);
  assign w_push = w_commit & w_keep;

  always_ff @(posedge CLK_FAST) begin
    if (RESET_FAST) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (w_rise) w_state_nxt = S_HIGH;
      S_HIGH: if (!r_sync2) begin
        w_commit = 1'b1;
        // Filtered pulses skip the deadtime entirely.
        if (!w_keep || DEADTIME == 0) w_state_nxt = S_IDLE;
        else                          w_state_nxt = S_DEAD;
      end
      S_DEAD: if (r_dead == DW'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Event fields and deadtime counter.
  always_ff @(posedge CLK_FAST) begin
    if (RESET_FAST) begin
      r_ts   <= '0;
      r_tot  <= '0;
      r_sat  <= 1'b0;
      r_dead <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_rise) begin
          r_ts  <= r_cnt;
          r_tot <= TOT_WIDTH'(1);
          r_sat <= 1'b0;
        end
        S_HIGH: begin
          if (r_sync2) begin
            if (r_tot == TOT_MAX) r_sat <= 1'b1;
            else                  r_tot <= r_tot + 1'b1;
          end else begin
            r_dead <= DW'(DEADTIME);
          end
        end
        S_DEAD: r_dead <= r_dead - 1'b1;
        default: ;
      endcase
    end
  end

  assign w_evt_in = '{timestamp: r_ts, tot: r_tot, saturated: r_sat};
  assign w_pop    = EVT_VALID & EVT_READY;

  event_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(evt_t))) u_fifo (
    .i_clk   (CLK_FAST),
    .i_rst   (RESET_FAST),
    .i_push  (w_push),
    .i_din   (w_evt_in),
    .i_pop   (w_pop),
    .o_dout  (w_evt_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (FIFO_LEVEL)
  );

  always_ff @(posedge CLK_FAST) begin
    if (RESET_FAST) r_drop <= '0;
    else if (w_push && w_full && !w_pop && r_drop != '1) r_drop <= r_drop + 1'b1;
  end

  assign EVT_VALID     = ~w_empty;
  assign EVT_TIMESTAMP = w_evt_out.timestamp;
  assign EVT_TOT       = w_evt_out.tot;
  assign EVT_SATURATED = w_evt_out.saturated;
  assign DROP_COUNT    = r_drop;

endmodule

// File: doc/pulse_timestamper.md
# pulse_timestamper

Fast-domain front end for detector comparator pulses. It is clocked by the 200 MHz PLL clock and reset by the fast-domain power-on reset. It synchronises the asynchronous comparator output and timestamps each rising edge with a free-running counter. It measures time-over-threshold (ToT) and enqueues one event per pulse into a show-ahead FIFO, which the slow-side readout drains through a valid/ready interface.

## Interface
- TS_WIDTH, 24: timestamp counter width.
- TOT_WIDTH, 8: ToT field width; saturates at 2^TOT_WIDTH-1.
- FIFO_DEPTH, 16: event entries; power of two, at least 2.
- DEADTIME, 8: cycles PULSE_IN is ignored after each committed event; 0 is legal.
- MIN_WIDTH, 2: minimum ToT in cycles; used only with the filter (see Configuration).

Ports:
- CLK_FAST  in  1  200 MHz fast clock. One clock; no other clock enters.
- RESET_FAST  in  1  synchronous, active-high reset.
- PULSE_IN  in  1  asynchronous comparator output.
- EVT_VALID  out  1  head event available.
- EVT_READY  in  1  consumer accepts head event.
- EVT_TIMESTAMP  out  TS_WIDTH  head event rising-edge timestamp.
- EVT_TOT  out  TOT_WIDTH  head event ToT in cycles.
- EVT_SATURATED  out  1  head event ToT clipped.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  stored events.
- DROP_COUNT  out  16  events lost to FIFO full; saturates at 0xFFFF.

## Operation
- Input path: a 2-flop synchroniser (sync) feeds a previous-sample register (prev).
  - Rise = sync & !prev.
  - Fall = !sync & prev.
- Timestamp counter: free-running, +1 every cycle, wraps from all-ones to 0.
- FSM states: IDLE, HIGH, DEAD.
  - IDLE: on rise, latch the counter value into ts, set tot=1, clear sat, go to HIGH.
  - HIGH: if sync=1, tot=tot+1, saturating; sat=1 on any increment attempted at max. If sync=0, commit {ts, tot, sat}, load dead counter=DEADTIME, go to DEAD, or go to IDLE if DEADTIME=0.
  - DEAD: decrement the dead counter; PULSE_IN is ignored. Go to IDLE in the cycle the counter reaches 0.
  - prev keeps updating in every state. A level still high on return to IDLE does not trigger until it falls and rises again.
- Commit: push into the FIFO in the commit cycle.
  - FIFO full and no pop in the same cycle: discard the event and increment DROP_COUNT, saturating.
  - FIFO full with a pop in the same cycle: accept the push; level unchanged.
- Readout: EVT_VALID = FIFO not empty. The EVT_* outputs show the head entry. A pop occurs on EVT_VALID & EVT_READY. EVT_* outputs are don't-care while EVT_VALID=0.
- Reset values:
  - Outputs: EVT_VALID=0, FIFO_LEVEL=0, DROP_COUNT=0, EVT_* data=0.
  - Internal: counter=0, FSM=IDLE, sync=0, prev=1.
  - Because prev resets to 1, a pulse already high at reset release produces no event.
- Reset mid-pulse or mid-deadtime: the in-flight event and all FIFO contents are discarded.

## Timing
- PULSE_IN rise to rise detection: 3 cycles, ±1 for async sampling.
- ts = counter value in the rise-detection cycle.
- A sync-high run of N cycles gives tot=N when N ≤ 2^TOT_WIDTH-1.
- Commit cycle to EVT_VALID=1 (FIFO previously empty): 1 cycle.
- Pop to the next head entry on the EVT_* outputs: 0 cycles (show-ahead).
- Pop to FIFO_LEVEL update: 1 cycle.
- Sustained throughput: one event per 2+DEADTIME cycles at minimum.

## Configuration
- MIN_WIDTH_FILTER_EN defined: a commit with tot < MIN_WIDTH is discarded and not counted in DROP_COUNT. The FSM goes straight to IDLE with no deadtime.
- MIN_WIDTH_FILTER_EN undefined: every pulse commits and MIN_WIDTH is ignored.

## Structure
- Shared package pulse_ts_pkg holds:
  - FSM state enum;
  - event record typedef {timestamp, tot, saturated};
  - DROP_COUNT width constant.
- Sub-module event_fifo: synchronous show-ahead FIFO with push/pop, full/empty and level outputs, parameterised on depth and record width.
- The synchroniser, counter and FSM live in the top module.

## Test plan
- Single pulse: after reset, PULSE_IN high 10 cycles with the rise detected at counter=100 -> one event, TIMESTAMP=100, TOT=10, SATURATED=0, EVT_VALID high 1 cycle after the commit.
- Saturation: PULSE_IN high 300 cycles, TOT_WIDTH=8 -> TOT=255, SATURATED=1.
- Overflow: EVT_READY=0, 18 pulses, FIFO_DEPTH=16 -> FIFO_LEVEL=16, DROP_COUNT=2. Then EVT_READY=1 -> 16 events in order with increasing timestamps, then EVT_VALID=0.
- Deadtime: 4-cycle pulse, then a 2-cycle pulse starting 3 cycles after the fall, DEADTIME=8 -> exactly one event, TOT=4.
- Filter: 1-cycle pulse with MIN_WIDTH=2 -> with MIN_WIDTH_FILTER_EN, no event and DROP_COUNT=0; without it, one event with TOT=1.
- Reset mid-pulse: assert RESET_FAST during a pulse and hold PULSE_IN high across release -> no event. The next clean pulse is timestamped relative to the counter restarting at 0.
